// File: rtl/block_sram_writer_pkg.sv
// rtl/block_sram_writer_pkg.sv - shared state types, segment encoding and SRAM layout constants
package block_sram_writer_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M1_UPSAMPLE_CSC,
        M2_IDCT,
        M3_COMPRESS
    } milestone_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RD_EVEN,
        S_RD_ODD,
        S_DONE
    } writer_state_t;

    typedef enum logic [1:0] {
        SEG_Y       = 2'd0,
        SEG_U       = 2'd1,
        SEG_V       = 2'd2,
        SEG_ILLEGAL = 2'd3
    } segment_t;

    localparam logic [17:0] DEF_Y_BASE    = 18'd0;
    localparam logic [17:0] DEF_U_BASE    = 18'd38400;
    localparam logic [17:0] DEF_V_BASE    = 18'd57600;
    localparam logic [17:0] DEF_Y_STRIDE  = 18'd160;
    localparam logic [17:0] DEF_UV_STRIDE = 18'd80;

    localparam logic [4:0] LAST_PAIR   = 5'd31;
    localparam logic [5:0] LAST_SAMPLE = 6'd63;

endpackage

// File: rtl/pixel_clip_pack.sv
// rtl/pixel_clip_pack.sv - saturate two signed IDCT samples to 8 bits and pack them into one SRAM word
module pixel_clip_pack (
    input  logic signed [31:0] even_i,
    input  logic signed [31:0] odd_i,
    output logic        [15:0] packed_o
);

    function automatic logic [7:0] clip8(input logic signed [31:0] s);
        if (s < 32'sd0) begin
            return 8'd0;
        end else if (s > 32'sd255) begin
            return 8'd255;
        end else begin
            return s[7:0];
        end
    endfunction

    // Even column occupies the high byte so a word reads left-to-right as on screen.
    assign packed_o = {clip8(even_i), clip8(odd_i)};

endmodule

// File: rtl/block_sram_writer.sv
// rtl/block_sram_writer.sv - stream one 8x8 IDCT block from the dual-port RAM into SRAM as packed pixel pairs
module block_sram_writer
    import block_sram_writer_pkg::*;
#(
    parameter logic [17:0] Y_BASE    = DEF_Y_BASE,
    parameter logic [17:0] U_BASE    = DEF_U_BASE,
    parameter logic [17:0] V_BASE    = DEF_V_BASE,
    parameter logic [17:0] Y_STRIDE  = DEF_Y_STRIDE,
    parameter logic [17:0] UV_STRIDE = DEF_UV_STRIDE
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic        [1:0]  Segment,
    input  logic        [4:0]  Block_row,
    input  logic        [5:0]  Block_col,
    output logic        [5:0]  DP_address,
    input  logic signed [31:0] DP_read_data,
    output logic        [17:0] SRAM_address,
    output logic        [15:0] SRAM_write_data,
    output logic               SRAM_we_n,
    output logic               Busy,
    output logic               Done
);

    writer_state_t      state_q,   state_d;
    logic        [5:0]  dp_addr_q, dp_addr_d;
    logic        [4:0]  pair_q,    pair_d;
    logic        [17:0] origin_q,  origin_d;
    logic        [17:0] stride_q,  stride_d;
    logic signed [31:0] even_q,    even_d;
    logic               we_n_q,    we_n_d;
    logic        [17:0] addr_q,    addr_d;
    logic        [15:0] wdata_q,   wdata_d;
    logic               done_q,    done_d;

    segment_t           seg;
    logic        [17:0] sel_base;
    logic        [17:0] sel_stride;
    logic        [15:0] packed_pair;

    assign seg = segment_t'(Segment);

    always_comb begin
        sel_base   = Y_BASE;
        sel_stride = Y_STRIDE;
        case (seg)
            SEG_U: begin
                sel_base   = U_BASE;
                sel_stride = UV_STRIDE;
            end
            SEG_V: begin
                sel_base   = V_BASE;
                sel_stride = UV_STRIDE;
            end
            default: begin
                sel_base   = Y_BASE;
                sel_stride = Y_STRIDE;
            end
        endcase
    end

    pixel_clip_pack u_clip (
        .even_i   (even_q),
        .odd_i    (DP_read_data),
        .packed_o (packed_pair)
    );

    always_comb begin
        state_d   = state_q;
        dp_addr_d = dp_addr_q;
        pair_d    = pair_q;
        origin_d  = origin_q;
        stride_d  = stride_q;
        even_d    = even_q;
        we_n_d    = 1'b1;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start && (seg != SEG_ILLEGAL)) begin
                    state_d   = S_PRIME;
                    dp_addr_d = 6'd0;
                    pair_d    = 5'd0;
                    // Top-left word of the block; per-pair offsets are added during the transfer.
                    origin_d  = sel_base + 18'({Block_row, 3'b000}) * sel_stride
                              + 18'({Block_col, 2'b00});
                    stride_d  = sel_stride;
                end
            end
            S_PRIME: begin
                state_d   = S_RD_EVEN;
                dp_addr_d = dp_addr_q + 6'd1;
            end
            S_RD_EVEN: begin
                state_d = S_RD_ODD;
                even_d  = DP_read_data;
                if (dp_addr_q != LAST_SAMPLE) begin
                    dp_addr_d = dp_addr_q + 6'd1;
                end
            end
            S_RD_ODD: begin
                we_n_d  = 1'b0;
                addr_d  = origin_q + 18'(pair_q[4:2]) * stride_q + 18'(pair_q[1:0]);
                wdata_d = packed_pair;
                pair_d  = pair_q + 5'd1;
                state_d = (pair_q == LAST_PAIR) ? S_DONE : S_RD_EVEN;
                if (dp_addr_q != LAST_SAMPLE) begin
                    dp_addr_d = dp_addr_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            dp_addr_q <= 6'd0;
            pair_q    <= 5'd0;
            origin_q  <= 18'd0;
            stride_q  <= 18'd0;
            even_q    <= 32'sd0;
            we_n_q    <= 1'b1;
            addr_q    <= 18'd0;
            wdata_q   <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dp_addr_q <= dp_addr_d;
            pair_q    <= pair_d;
            origin_q  <= origin_d;
            stride_q  <= stride_d;
            even_q    <= even_d;
            we_n_q    <= we_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    assign DP_address      = dp_addr_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = (state_q != S_IDLE);
    assign Done            = done_q;

endmodule

// File: tb/tb_block_sram_writer.sv
// tb/tb_block_sram_writer.sv - self-checking bench for block_sram_writer against a pixel-level reference model
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); end end

module tb_block_sram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  seg;
    logic [4:0]  row;
    logic [5:0]  col;
    logic [5:0]  dp_addr;
    logic [31:0] dp_rd;
    logic [17:0] sram_addr;
    logic [15:0] sram_wd;
    logic        we_n;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int mem [64];
    int obs_addr [32];
    int obs_data [32];
    int wcount;

    always #5 clk = ~clk;

    always @(posedge clk) dp_rd <= mem[dp_addr];

    block_sram_writer dut (
        .Clock           (clk),
        .Reset           (rst),
        .Start           (start),
        .Segment         (seg),
        .Block_row       (row),
        .Block_col       (col),
        .DP_address      (dp_addr),
        .DP_read_data    (dp_rd),
        .SRAM_address    (sram_addr),
        .SRAM_write_data (sram_wd),
        .SRAM_we_n       (we_n),
        .Busy            (busy),
        .Done            (done)
    );

    function automatic int clip(int s);
        return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    endfunction

    function automatic int exp_addr(int s, int r, int c, int p);
        int base, stride;
        base   = (s == 0) ? 0 : ((s == 1) ? 38400 : 57600);
        stride = (s == 0) ? 160 : 80;
        return base + (r * 8 + p / 4) * stride + c * 4 + p % 4;
    endfunction

    function automatic int exp_data(int p);
        return clip(mem[2 * p]) * 256 + clip(mem[2 * p + 1]);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 64; k++) begin
            mem[k] = int'($urandom_range(0, 700)) - 200;
            if ($urandom_range(0, 9) == 0) mem[k] = int'($urandom);
        end
    endtask

    task automatic start_pulse(input int s, input int r, input int c);
        @(negedge clk);
        start = 1'b1;
        seg   = s[1:0];
        row   = r[4:0];
        col   = c[5:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes cycles 1..last_cyc of a block started in cycle 0; optionally injects a
    // stray Start, a chained Start in the last cycle, or a Reset in the last cycle.
    task automatic monitor(input int s, input int r, input int c, input int last_cyc,
                           input bit chain, input int ns, input int nr, input int nc,
                           input int ign_at, input bit abort);
        int busy_bad, dp_bad, done_bad, done_cnt, exp_w, exp_done;
        busy_bad = 0; dp_bad = 0; done_bad = 0; done_cnt = 0; wcount = 0;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            if (busy !== (cyc <= 66)) busy_bad++;
            if (cyc <= 64 && dp_addr !== 6'(cyc - 1)) dp_bad++;
            if (done !== (cyc == 67)) done_bad++;
            if (done === 1'b1) done_cnt++;
            if (we_n === 1'b0) begin
                if (wcount < 32) begin
                    `CHK("wr_cycle", cyc, 4 + 2 * wcount)
                    `CHK("wr_addr", int'(sram_addr), exp_addr(s, r, c, wcount))
                    `CHK("wr_data", int'(sram_wd), exp_data(wcount))
                    obs_addr[wcount] = int'(sram_addr);
                    obs_data[wcount] = int'(sram_wd);
                end
                wcount++;
            end
            if (cyc == ign_at) begin
                start = 1'b1; seg = 2'd1; row = 5'd3; col = 6'd5;
            end
            if (chain && cyc == last_cyc) begin
                start = 1'b1; seg = ns[1:0]; row = nr[4:0]; col = nc[5:0];
            end
            if (abort && cyc == last_cyc) rst = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        exp_w    = (last_cyc < 4) ? 0 : ((last_cyc - 4) / 2 + 1);
        if (exp_w > 32) exp_w = 32;
        exp_done = (last_cyc >= 67) ? 1 : 0;
        `CHK("wr_count", wcount, exp_w)
        `CHK("done_count", done_cnt, exp_done)
        `CHK("done_pattern", done_bad, 0)
        `CHK("busy_pattern", busy_bad, 0)
        `CHK("dp_addr_seq", dp_bad, 0)
    endtask

    task automatic check_reset_outputs();
        `CHK("rst_we_n", we_n, 1'b1)
        `CHK("rst_addr", sram_addr, 18'd0)
        `CHK("rst_wdata", sram_wd, 16'd0)
        `CHK("rst_dp_addr", dp_addr, 6'd0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
    endtask

    task automatic watch_quiet(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (we_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        `CHK(tag, bad, 0)
    endtask

    initial begin
        int s, r, c;
        rst = 1'b1; start = 1'b0; seg = 2'd0; row = 5'd0; col = 6'd0;
        for (int k = 0; k < 64; k++) mem[k] = k;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        start_pulse(0, 0, 0);
        monitor(0, 0, 0, 69, 1'b0, 0, 0, 0, -1, 1'b0);
        `CHK("y00_first_addr", obs_addr[0], 0)
        `CHK("y00_row1_addr", obs_addr[4], 160)
        `CHK("y00_last_addr", obs_addr[31], 1123)
        `CHK("y00_first_word", obs_data[0], 32'h0001)
        `CHK("y00_last_word", obs_data[31], 32'h3E3F)

        fill_random();
        start_pulse(0, 29, 39);
        monitor(0, 29, 39, 69, 1'b0, 0, 0, 0, -1, 1'b0);
        `CHK("y_last_first_addr", obs_addr[0], 37276)
        `CHK("y_last_last_addr", obs_addr[31], 38399)

        fill_random();
        start_pulse(1, 0, 19);
        monitor(1, 0, 19, 69, 1'b0, 0, 0, 0, 30, 1'b0);
        `CHK("u_first_addr", obs_addr[0], 38476)
        `CHK("u_row1_addr", obs_addr[4], 38556)

        fill_random();
        mem[0] = -5; mem[1] = 300; mem[2] = 128; mem[3] = 255;
        start_pulse(2, 0, 0);
        monitor(2, 0, 0, 67, 1'b1, 0, 5, 7, -1, 1'b0);
        `CHK("v_first_addr", obs_addr[0], 57600)
        `CHK("clip_word0", obs_data[0], 32'h00FF)
        `CHK("clip_word1", obs_data[1], 32'h80FF)
        monitor(0, 5, 7, 69, 1'b0, 0, 0, 0, -1, 1'b0);

        start_pulse(3, 2, 2);
        watch_quiet(80, "illegal_segment_quiet");

        fill_random();
        start_pulse(0, 10, 10);
        monitor(0, 10, 10, 20, 1'b0, 0, 0, 0, -1, 1'b1);
        check_reset_outputs();
        rst = 1'b0;
        watch_quiet(70, "abort_quiet");
        fill_random();
        start_pulse(1, 7, 11);
        monitor(1, 7, 11, 69, 1'b0, 0, 0, 0, -1, 1'b0);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            s = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 29));
            c = (s == 0) ? int'($urandom_range(0, 39)) : int'($urandom_range(0, 19));
            start_pulse(s, r, c);
            monitor(s, r, c, 69, 1'b0, 0, 0, 0, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_sram_writer.md
BLOCK_SRAM_WRITER -- requirements
Module: block_sram_writer

Interface
REQ-001 SHALL have parameter Y_BASE, default 18'd0, meaning the SRAM word address of the Y segment.
REQ-002 SHALL have parameter U_BASE, default 18'd38400, meaning the SRAM word address of the U segment.
REQ-003 SHALL have parameter V_BASE, default 18'd57600, meaning the SRAM word address of the V segment.
REQ-004 SHALL have parameter Y_STRIDE, default 18'd160, meaning the Y row pitch in 16-bit words.
REQ-005 SHALL have parameter UV_STRIDE, default 18'd80, meaning the U/V row pitch in 16-bit words.
REQ-006 Clock  in  1  the single clock; all logic is on the rising edge.
REQ-007 Reset  in  1  reset, synchronous and active-high.
REQ-008 Start  in  1  single-cycle request to write one 8x8 block.
REQ-009 Segment  in  2  0=Y, 1=U, 2=V; 3 is illegal.
REQ-010 Block_row  in  5  block row index, 0..29.
REQ-011 Block_col  in  6  block column index, 0..39 for Y and 0..19 for U/V.
REQ-012 DP_address  out  6  registered read address into the dual-port RAM that holds IDCT results, row-major r*8+c.
REQ-013 DP_read_data  in  32  signed IDCT sample for the DP_address of the previous cycle.
REQ-014 SRAM_address  out  18  registered SRAM word address.
REQ-015 SRAM_write_data  out  16  registered packed pixel pair.
REQ-016 SRAM_we_n  out  1  active-low write enable.
REQ-017 Busy  out  1  high while a block transfer is in progress.
REQ-018 Done  out  1  one-cycle pulse when a block transfer completes.

Function
REQ-019 SHALL sample Start, Segment, Block_row and Block_col only in S_IDLE; Start in any other state SHALL be ignored.
REQ-020 A Start with Segment==3 SHALL be ignored: no write, no Done.
REQ-021 States: S_IDLE -> S_PRIME (1 cycle) -> alternating S_RD_EVEN/S_RD_ODD (32 pairs) -> S_DONE (1 cycle) -> S_IDLE.
REQ-022 Taking cycle 0 as the Start cycle, DP_address SHALL equal k in cycle 1+k for k=0..63.
REQ-023 Pair p (p=0..31) SHALL be written with SRAM_we_n low in cycle 4+2p only; SRAM_we_n SHALL be high in every other cycle.
REQ-024 Busy SHALL be high in cycles 1..66; Done SHALL be high in cycle 67 only, with Busy low in that cycle.
REQ-025 Pair address SHALL be base + (Block_row*8 + r)*stride + Block_col*4 + c/2, where r=p/4 and c=2*(p%4).
REQ-026 Each sample SHALL be clipped to 0..255: negative values give 0, values >255 give 255, otherwise the low 8 bits.
REQ-027 SRAM_write_data SHALL be {clip(even pixel), clip(odd pixel)}, with the even column in [15:8].
REQ-028 Address arithmetic SHALL be unsigned 18-bit with no wrap; the last Y pixel pair maps to 38399.
REQ-029 A Start in the Done cycle SHALL be accepted, since that cycle is S_IDLE, giving back-to-back blocks 67 cycles apart.

Reset
REQ-030 While Reset is high, on the clock edge the block SHALL go to S_IDLE with SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, DP_address=0, Busy=0 and Done=0.
REQ-031 Reset asserted mid-block SHALL abort the transfer: no write after the Reset edge and no Done for the aborted block.

Structure
REQ-032 The state enum, the segment encoding and the base/stride defaults SHALL live in the shared state/constant package alongside the existing milestone state types.
REQ-033 The clip-and-pack logic SHALL be one combinational sub-module, pixel_clip_pack (two 32-bit inputs, one 16-bit output).

Verification
REQ-034 Y, row 0, col 0, DP RAM filled with k for sample k: writes go to 0,1,2,3,160..163,...,1120..1123; word 0 = 16'h0001; the last word at 1123 = 16'h3E3F.
REQ-035 Y, row 29, col 39: first address 37276, last address 38399, exactly 32 writes, Done in cycle 67.
REQ-036 U, row 0, col 19: first address 38476, row-1 address 38556; V, row 0, col 0: first address 57600.
REQ-037 Samples -5, 300, 128, 255: packed words 16'h00FF and 16'h80FF.
REQ-038 Reset in cycle 20: SRAM_we_n stays high afterwards and no Done; a new Start after release produces a normal 32-write block.
REQ-039 Start pulsed during Busy and Segment=3 in S_IDLE are both ignored; Start in the Done cycle gives its first write 4 cycles later.
